// File: rtl/arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : arb_pkg                                                    |
// | Shared constants, FSM state type and index helper for the            |
// | request-latching round-robin arbiter feeding the 8-to-3 encoder.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package arb_pkg;

   // Request width; fixed to match the downstream encoder input count.
   localparam int N_REQ = 8;
   // Encoder-facing index width (log2 of N_REQ).
   localparam int ENC_W = 3;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // Convert a one-hot vector to its bit index; an all-zero vector gives 0.
   function automatic logic [ENC_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
      logic [ENC_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (oh[i]) begin
            idx = idx | ENC_W'(i);
         end
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/req_latch_rr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : req_latch_rr_arbiter_if                                  |
// | Request / acknowledge / grant bundle between the requesters, the     |
// | arbiter (slave) and the consumer side (master).                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface req_latch_rr_arbiter_if;
   import arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic             ack;
   logic             ovf_clr;
   logic [N_REQ-1:0] grant;
   logic             grant_valid;
   logic [N_REQ-1:0] pending;
   logic             ovf;

   modport master (
      output req, ack, ovf_clr,
      input  grant, grant_valid, pending, ovf
   );

   modport slave (
      input  req, ack, ovf_clr,
      output grant, grant_valid, pending, ovf
   );

endinterface
`default_nettype wire

// File: rtl/req_latch_rr_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rr_pick                                                     |
// | Combinational round-robin selector: first set bit of pending_i,      |
// | searching upward from ptr_i with wrap, returned as one-hot.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_pick
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] pending_i,
   input  logic [ENC_W-1:0] ptr_i,
   output logic [N_REQ-1:0] onehot_o
);

   logic             found;
   logic [ENC_W-1:0] idx;

   // Walk ptr, ptr+1, ... (3-bit add wraps 7 -> 0) and keep the first hit only.
   always_comb begin
      onehot_o = '0;
      found    = 1'b0;
      idx      = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = ptr_i + ENC_W'(i);
         if (!found && pending_i[idx]) begin
            onehot_o[idx] = 1'b1;
            found         = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/req_latch_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : req_latch_rr_arbiter                                        |
// | Latches rising request edges into sticky pending bits and hands out  |
// | one held, one-hot grant at a time in round-robin order.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module req_latch_rr_arbiter
   import arb_pkg::*;
#(
   parameter int SYNC_STAGES = 2   // 0 (bypass) or 2
)
(
   input  logic                   clk,
   input  logic                   rst,
   req_latch_rr_arbiter_if.slave  arb_io
);

   logic [N_REQ-1:0] req_s;
   logic [N_REQ-1:0] req_q;
   logic [N_REQ-1:0] req_edge;
   logic [N_REQ-1:0] clr_mask;
   logic [N_REQ-1:0] picked;
   logic             accept;
   logic             ovf_set;

   state_e           state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic             grant_valid_q, grant_valid_d;
   logic [ENC_W-1:0] ptr_q, ptr_d;
   logic [N_REQ-1:0] pending_q, pending_d;
   logic             ovf_q, ovf_d;

   generate
      if (SYNC_STAGES == 0) begin : g_sync_bypass
         assign req_s = arb_io.req;
      end else begin : g_sync_2ff
         logic [N_REQ-1:0] meta_q;
         logic [N_REQ-1:0] sync_q;
         // Two-flop synchroniser on the asynchronous request lines.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               meta_q <= '0;
               sync_q <= '0;
            end else begin
               meta_q <= arb_io.req;
               sync_q <= meta_q;
            end
         end
         assign req_s = sync_q;
      end
   endgenerate

   rr_pick u_rr_pick (
      .pending_i (pending_q),
      .ptr_i     (ptr_q),
      .onehot_o  (picked)
   );

   // Only a rising edge is a new request; a held-high line adds nothing.
   assign req_edge = req_s & ~req_q;
   assign accept   = (state_q == GRANT) && arb_io.ack;
   assign clr_mask = accept ? grant_q : '0;

   // A fresh edge on the bit being retired this cycle simply re-arms it.
   assign ovf_set   = |(req_edge & pending_q & ~clr_mask);
   assign pending_d = (pending_q & ~clr_mask) | req_edge;
   assign ovf_d     = ovf_set ? 1'b1 : (arb_io.ovf_clr ? 1'b0 : ovf_q);

   // State register plus all datapath flops; reset drops everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         ptr_q         <= '0;
         pending_q     <= '0;
         ovf_q         <= 1'b0;
         req_q         <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         ptr_q         <= ptr_d;
         pending_q     <= pending_d;
         ovf_q         <= ovf_d;
         req_q         <= req_s;
      end
   end

   // Next-state: leave IDLE on any pending bit, leave GRANT on ack.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|pending_q) state_d = GRANT;
         GRANT:   if (arb_io.ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Grant/pointer updates: load a pick from IDLE, retire and advance on ack.
   always_comb begin
      grant_d       = grant_q;
      grant_valid_d = grant_valid_q;
      ptr_d         = ptr_q;
      if ((state_q == IDLE) && (|pending_q)) begin
         grant_d       = picked;
         grant_valid_d = 1'b1;
      end else if (accept) begin
         grant_d       = '0;
         grant_valid_d = 1'b0;
         ptr_d         = onehot_to_idx(grant_q) + ENC_W'(1);
      end
   end

   assign arb_io.grant       = grant_q;
   assign arb_io.grant_valid = grant_valid_q;
   assign arb_io.pending     = pending_q;
   assign arb_io.ovf         = ovf_q;

endmodule
`default_nettype wire

// File: doc/req_latch_rr_arbiter.md
Name: req_latch_rr_arbiter

Overview:
- Upstream stage of the 8-to-3 encoder.
- Captures rising edges on 8 request lines into sticky pending bits.
- Selects one pending request by round-robin and presents it as a guaranteed one-hot (or all-zero) grant vector. That vector drives the encoder inputs i0..i7, so the encoder never sees more than one active input.
- Each grant is held until the consumer acknowledges it.

Parameters:
- N_REQ, 8, number of request lines; fixed at 8 to match encoder width.
- SYNC_STAGES, 2, synchroniser flops on req before edge detect; legal values 0 or 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  8  request lines; bit k maps to encoder input ik.
- ack  in  1  consumer acknowledge of the current grant.
- ovf_clr  in  1  clears the sticky overflow flag.
- grant  out  8  one-hot grant to encoder i7..i0; all-zero when idle.
- grant_valid  out  1  high while grant is non-zero.
- pending  out  8  latched, not-yet-serviced requests.
- ovf  out  1  sticky: a request edge was lost.

Behaviour:
Reset (async, rst=1):
- grant=0, grant_valid=0, pending=0, ovf=0.
- RR pointer ptr=0, state=IDLE.
- Synchroniser flops and req_q clear to 0. A req already high at reset release therefore registers as an edge.

Input path:
- req passes through SYNC_STAGES flops to give req_s.
- req_q is req_s delayed by one cycle.
- edge = req_s & ~req_q. Only rising edges count; level-high holds nothing further.

Pending set:
- pending <= (pending & ~clr_mask) | edge on every clock.
- clr_mask is the granted bit on an accepted ack, otherwise 0.

Latency:
- With SYNC_STAGES=0, req rising before edge k sets pending at edge k. grant is set at edge k+1 if the block is IDLE.
- SYNC_STAGES=2 adds exactly 2 cycles.

State machine: IDLE, GRANT.
- IDLE, pending!=0: at the next edge, grant <= rr_pick(pending, ptr), grant_valid <= 1, state goes to GRANT.
- IDLE, pending==0: stay in IDLE, grant=0.
- GRANT, ack=0: grant held stable. New edges only set pending bits and never change grant.
- GRANT, ack=1 at an edge:
  - grant <= 0, grant_valid <= 0.
  - The granted pending bit is cleared.
  - ptr <= (granted index + 1) mod 8.
  - state goes to IDLE.
- grant is therefore low for at least one cycle between consecutive grants.
- ack while in IDLE is ignored.

Round-robin:
- rr_pick searches ptr, ptr+1, ..., wrapping 7 back to 0, and returns the first set bit as one-hot.
- After reset the lowest index wins.

Overflow:
- ovf sets when edge[k]=1 and pending[k]=1 and bit k is not being cleared in the same cycle.
- If the granted bit is acked and a new edge arrives on that bit in the same cycle, the bit stays pending and ovf is not set.
- ovf_clr clears ovf. When set and clear happen together, set wins.

Invariant: grant is always one-hot or zero ($onehot0), in every cycle.

Reset mid-grant: grant drops asynchronously and all pending requests are discarded.

Decomposition:
- Shared package arb_pkg: N_REQ=8 constant and state enum {IDLE, GRANT}. The encoder-facing width constant also lives there for reuse.
- One natural sub-module: rr_pick. It is purely combinational: inputs pending[7:0] and ptr[2:0], output onehot[7:0]. It is unit-testable on its own against a reference loop.

Test Plan (SYNC_STAGES=0 unless stated):
- Reset then single pulse on req[5]: pending=8'h20 one cycle later, then grant=8'h20 and grant_valid=1 on the next edge. Ack gives grant=0, pending=0, ptr=6.
- req=8'h81 rising together from reset: first grant=8'h01. After ack, grant=8'h80 following exactly one idle cycle. Then pending=0.
- Fairness: ptr=6 with pending=8'h41 gives grant=8'h40. After ack, grant=8'h01 (wrap). The bench checks $onehot0(grant) every cycle.
- Overflow: req[2] pulses twice while grant=8'h08 is held unacked, so ovf=1. ovf_clr and a new overflow edge in the same cycle leave ovf=1. ovf_clr alone gives ovf=0.
- Ack with a same-cycle new edge on the granted bit: pending bit stays 1, ovf stays 0, and that bit is re-granted after one idle cycle.
- Async reset asserted mid-GRANT, between clock edges: grant, pending and ovf go to 0 immediately. SYNC_STAGES=2: the req-to-grant latency measured is 2 cycles longer than with SYNC_STAGES=0.
